controle_movimento: RTL

//  Movement sequencer for the autonomous toy. Owns a prescaled 4-bit tick counter and an FSM

---
 rtl/controle_movimento.sv | 139 +++++++++++++
 1 files changed

// File: rtl/controle_movimento.sv
// Movement sequencer: prescaled tick counter plus FSM timing forward/reverse/turn phases
// and driving both motor commands. Outputs are all registered.
module controle_movimento #(
    parameter int PRESC    = 10,
    parameter int T_FRENTE = 12,
    parameter int T_RE     = 4,
    parameter int T_GIRO   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       obstaculo,
    output logic [1:0] motor_esq,
    output logic [1:0] motor_dir,
    output logic [1:0] estado,
    output logic [3:0] contagem,
    output logic [3:0] giros,
    output logic       sentido
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC - 1);

    localparam logic [1:0] PARADO = 2'd0;
    localparam logic [1:0] FRENTE = 2'd1;
    localparam logic [1:0] RE     = 2'd2;
    localparam logic [1:0] GIRO   = 2'd3;

    localparam logic [1:0] M_OFF = 2'b00;
    localparam logic [1:0] M_FWD = 2'b01;
    localparam logic [1:0] M_REV = 2'b10;

    logic          obs_m_q, obs_s_q;
    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    contagem_q, contagem_d;
    logic [3:0]    giros_q, giros_d;
    logic          sentido_q, sentido_d;
    logic [1:0]    motor_esq_q, motor_esq_d;
    logic [1:0]    motor_dir_q, motor_dir_d;
    logic [3:0]    fim;
    logic          tick, fase_fim;

    // State register and all datapath flops, including the obstacle synchronizer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            obs_m_q     <= 1'b0;
            obs_s_q     <= 1'b0;
            state_q     <= PARADO;
            presc_q     <= '0;
            contagem_q  <= 4'd0;
            giros_q     <= 4'd0;
            sentido_q   <= 1'b0;
            motor_esq_q <= M_OFF;
            motor_dir_q <= M_OFF;
        end else begin
            obs_m_q     <= obstaculo;
            obs_s_q     <= obs_m_q;
            state_q     <= state_d;
            presc_q     <= presc_d;
            contagem_q  <= contagem_d;
            giros_q     <= giros_d;
            sentido_q   <= sentido_d;
            motor_esq_q <= motor_esq_d;
            motor_dir_q <= motor_dir_d;
        end
    end

    always_comb begin
        fim = 4'd0;
        case (state_q)
            FRENTE:  fim = 4'(T_FRENTE - 1);
            RE:      fim = 4'(T_RE - 1);
            GIRO:    fim = 4'(T_GIRO - 1);
            default: fim = 4'd0;
        endcase
    end

    assign tick     = (state_q != PARADO) && (presc_q == PRESC_MAX);
    assign fase_fim = tick && (contagem_q == fim);

    // Next state: stop wins over everything, obstacle wins over forward phase end.
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = PARADO;
        end else begin
            case (state_q)
                PARADO:  if (start) state_d = FRENTE;
                FRENTE:  if (obs_s_q) state_d = RE;
                         else if (fase_fim) state_d = GIRO;
                RE:      if (fase_fim) state_d = GIRO;
                GIRO:    if (fase_fim) state_d = FRENTE;
                default: state_d = PARADO;
            endcase
        end
    end

    // Outputs and counters, all computed for the next state.
    always_comb begin
        presc_d     = presc_q;
        contagem_d  = contagem_q;
        giros_d     = giros_q;
        sentido_d   = sentido_q;
        motor_esq_d = M_OFF;
        motor_dir_d = M_OFF;
        if (state_d != state_q) begin
            presc_d    = '0;
            contagem_d = 4'd0;
        end else if (state_q != PARADO) begin
            if (tick) begin
                presc_d    = '0;
                contagem_d = contagem_q + 4'd1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
        if (state_q == GIRO && state_d == FRENTE) giros_d = giros_q + 4'd1;
        if (state_q != GIRO && state_d == GIRO) sentido_d = ~sentido_q;
        case (state_d)
            FRENTE: begin motor_esq_d = M_FWD; motor_dir_d = M_FWD; end
            RE:     begin motor_esq_d = M_REV; motor_dir_d = M_REV; end
            GIRO: begin
                motor_esq_d = sentido_d ? M_REV : M_FWD;
                motor_dir_d = sentido_d ? M_FWD : M_REV;
            end
            default: begin motor_esq_d = M_OFF; motor_dir_d = M_OFF; end
        endcase
    end

    assign estado    = state_q;
    assign contagem  = contagem_q;
    assign giros     = giros_q;
    assign sentido   = sentido_q;
    assign motor_esq = motor_esq_q;
    assign motor_dir = motor_dir_q;

endmodule
